// File: rtl/wb_trace_buffer.sv
// Writeback-commit trace buffer: captures (pc, rd, data) records with a PC trigger and freeze.
// Optional macro TRACE_TIMESTAMP_EN adds a free-running cycle stamp to every record.
module wb_trace_buffer #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned PC_W      = 32,
  parameter int unsigned TS_W      = 16,
  parameter int unsigned WRAP      = 1,
  parameter int unsigned POST_TRIG = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_valid,
  input  logic [4:0]                 wb_rd_addr,
  input  logic [DATA_W-1:0]          wb_rd_data,
  input  logic [PC_W-1:0]            wb_pc,
  input  logic                       arm,
  input  logic                       trig_en,
  input  logic [PC_W-1:0]            trig_pc,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [PC_W-1:0]            rd_pc,
  output logic [4:0]                 rd_addr,
  output logic [DATA_W-1:0]          rd_data,
  output logic [TS_W-1:0]            rd_ts,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [1:0]                 state
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam bit          WRAP_EN = (WRAP != 0);

  typedef enum logic [1:0] {
    ST_ARMED     = 2'b00,
    ST_TRIGGERED = 2'b01,
    ST_FROZEN    = 2'b10
  } state_t;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [4:0]        addr;
    logic [DATA_W-1:0] data;
  } rec_t;

  rec_t             mem [DEPTH];
  state_t           state_q, state_n;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_n, rd_ptr_q, rd_ptr_n;
  logic [PTR_W-1:0] post_q, post_n;
  logic [CNT_W-1:0] count_q, count_n;
  logic             overflow_q, overflow_n;
  logic             capture, pop, full, wr_en, valid_n;
  rec_t             wr_rec, head_n;

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0]  ts_mem [DEPTH];
  logic [TS_W-1:0]  ts_q, ts_n, head_ts_n;
`endif

  assign count    = count_q;
  assign overflow = overflow_q;
  assign state    = state_q;

  // Next-state: pointer/count bookkeeping, trigger FSM and the show-ahead head for next cycle
  always_comb begin
    state_n    = state_q;
    wr_ptr_n   = wr_ptr_q;
    rd_ptr_n   = rd_ptr_q;
    post_n     = post_q;
    count_n    = count_q;
    overflow_n = overflow_q;
    wr_en      = 1'b0;
    head_n     = '0;
    valid_n    = 1'b0;
    wr_rec.pc   = wb_pc;
    wr_rec.addr = wb_rd_addr;
    wr_rec.data = wb_rd_data;

    capture = wb_valid && (wb_rd_addr != 5'd0) && (state_q != ST_FROZEN) && !arm;
    pop     = (count_q != '0) && rd_ready;
    full    = (count_q == CNT_W'(DEPTH));

    if (arm) begin
      state_n    = ST_ARMED;
      wr_ptr_n   = '0;
      rd_ptr_n   = '0;
      post_n     = '0;
      count_n    = '0;
      overflow_n = 1'b0;
    end else begin
      if (capture && (pop || !full || WRAP_EN)) begin
        wr_en    = 1'b1;
        wr_ptr_n = wr_ptr_q + PTR_W'(1);
      end
      // A wrapping overwrite of a full buffer retires the oldest entry like a pop
      if (pop || (wr_en && full)) begin
        rd_ptr_n = rd_ptr_q + PTR_W'(1);
      end
      if (wr_en && !pop && !full) begin
        count_n = count_q + CNT_W'(1);
      end else if (pop && !capture) begin
        count_n = count_q - CNT_W'(1);
      end
      if (capture && full && !pop) begin
        overflow_n = 1'b1;
      end

      case (state_q)
        ST_ARMED: begin
          if (capture && trig_en && (wb_pc == trig_pc)) begin
            if (POST_TRIG == 0) begin
              state_n = ST_FROZEN;
            end else begin
              state_n = ST_TRIGGERED;
              post_n  = PTR_W'(POST_TRIG);
            end
          end
        end
        ST_TRIGGERED: begin
          if (capture) begin
            post_n = post_q - PTR_W'(1);
            if (post_q == PTR_W'(1)) begin
              state_n = ST_FROZEN;
            end
          end
        end
        default: ;
      endcase
    end

    valid_n = (count_n != '0);
    if (valid_n) begin
      head_n = (wr_en && (rd_ptr_n == wr_ptr_q)) ? wr_rec : mem[rd_ptr_n];
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  always_comb begin
    ts_n      = arm ? '0 : ts_q + TS_W'(1);
    head_ts_n = '0;
    if (valid_n) begin
      head_ts_n = (wr_en && (rd_ptr_n == wr_ptr_q)) ? ts_q : ts_mem[rd_ptr_n];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      ts_mem[wr_ptr_q] <= ts_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q  <= '0;
      rd_ts <= '0;
    end else begin
      ts_q  <= ts_n;
      rd_ts <= head_ts_n;
    end
  end
`else
  assign rd_ts = '0;
`endif

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= wr_rec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_ARMED;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      post_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rd_valid   <= 1'b0;
      rd_pc      <= '0;
      rd_addr    <= '0;
      rd_data    <= '0;
    end else begin
      state_q    <= state_n;
      wr_ptr_q   <= wr_ptr_n;
      rd_ptr_q   <= rd_ptr_n;
      post_q     <= post_n;
      count_q    <= count_n;
      overflow_q <= overflow_n;
      rd_valid   <= valid_n;
      rd_pc      <= head_n.pc;
      rd_addr    <= head_n.addr;
      rd_data    <= head_n.data;
    end
  end

endmodule

// File: doc/wb_trace_buffer.md
Name: wb_trace_buffer

Overview:
- Parametrised writeback-commit trace buffer for the pipelined SCPU. It sits beside the WB stage and captures every architectural register write as a (pc, rd, data) record into a circular buffer.
- A PC-match trigger with a post-trigger window freezes capture. The frozen record set is drained through a valid/ready read port by the debug/bench side.
- Generalises per-register probing into a depth-, width- and mode-configurable history of retired writes.

Parameters:
DEPTH, 16, entries; power of 2, >=2
DATA_W, 32, width of rd_data/wb data
PC_W, 32, width of pc fields
TS_W, 16, timestamp width (used only with TRACE_TIMESTAMP_EN)
WRAP, 1, 1 = overwrite oldest when full; 0 = drop new when full
POST_TRIG, 8, captures stored after the trigger record before freezing (0..DEPTH-1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
wb_valid  in  1  WB stage commits a register write this cycle (RegWrite qualified)
wb_rd_addr  in  5  destination register
wb_rd_data  in  DATA_W  write data (Data_out_WB)
wb_pc  in  PC_W  PC of committing instruction
arm  in  1  pulse: clear buffer, enter ARMED
trig_en  in  1  enable PC-match trigger
trig_pc  in  PC_W  trigger PC
rd_ready  in  1  consumer pops head entry
rd_valid  out  1  head entry available
rd_pc  out  PC_W  head pc
rd_addr  out  5  head rd
rd_data  out  DATA_W  head data
rd_ts  out  TS_W  head timestamp
count  out  $clog2(DEPTH)+1  stored entries
overflow  out  1  sticky: an entry was overwritten or dropped
state  out  2  00 ARMED, 01 TRIGGERED, 10 FROZEN

Behaviour:
- Reset (async) and arm (sync) are identical in effect:
  - state=ARMED; wr/rd pointers=0; count=0; overflow=0; post counter=0; timestamp=0.
  - rd_valid=0; rd_pc/rd_addr/rd_data/rd_ts=0.
- Capture condition: wb_valid && wb_rd_addr!=0 && state!=FROZEN && !arm. Writes to x0 are never stored.
- arm and capture in the same cycle: arm wins, record discarded.
- Storage is a register array. Read is show-ahead: rd_* always show the head entry, and read 0 when empty.
- A record captured at edge N into an empty buffer gives rd_valid=1 after edge N.
- Pop occurs when rd_valid && rd_ready: rd_ptr+1 (mod DEPTH), count-1. Reads are allowed in any state.
- Capture when not full: store at wr_ptr, wr_ptr+1 (mod DEPTH), count+1.
- Capture when full, no pop:
  - WRAP=1: overwrite oldest; both pointers advance; count stays DEPTH; overflow=1.
  - WRAP=0: record dropped; pointers unchanged; overflow=1.
- Capture and pop in the same cycle: both happen; count unchanged; no overflow even if full.
- Pop when empty: ignored.
- ARMED -> TRIGGERED when trig_en && capture && wb_pc==trig_pc. The trigger record is stored; post counter loads POST_TRIG.
  - With POST_TRIG=0: ARMED -> FROZEN directly on the trigger capture.
- TRIGGERED: each capture stores the record and decrements the post counter. The capture that brings it to 0 moves to FROZEN.
  - A dropped capture (WRAP=0, full) still decrements.
  - A further trig_pc match in TRIGGERED has no effect.
- FROZEN: no captures; buffer drains via the read port; exits only via arm or rst.
- trig_en=0: stays ARMED and traces continuously as a rolling history.
- Pointers use binary wrap at DEPTH. count saturates at DEPTH and never exceeds it.

Optional Feature:
TRACE_TIMESTAMP_EN
- Defined:
  - TS_W-bit free-running cycle counter; increments every clk, wraps at 2^TS_W, cleared by rst/arm.
  - The counter value is stored with each record and driven on rd_ts.
- Undefined:
  - No counter and no timestamp storage; rd_ts is tied to 0.
  - Port list unchanged.

Test Plan:
- Defaults, trig_en=0: commit x1=5@pc 0x0, x2=7@0x4, x0=9@0x8 -> count=2, head {0x0,1,5}; pop -> head {0x4,2,7}; pop -> rd_valid=0.
- WRAP=1, DEPTH=4: 6 commits rd=1..6 -> count=4, overflow=1, drain order rd=3,4,5,6. WRAP=0 same stimulus -> drain 1,2,3,4, overflow=1.
- trig_pc=0x20, POST_TRIG=2: commits at pc 0x18, 0x1C, 0x20, 0x24, 0x28, 0x2C.
  - state=01 after 0x20, 10 after 0x28.
  - 0x2C not stored; count=5.
- Full buffer, WRAP=1: capture and rd_ready in the same cycle -> count stays 4, overflow stays 0, head advances by one.
- arm asserted with wb_valid in FROZEN (count=3) -> next cycle count=0, state=00, overflow=0, record dropped.
- rst asserted mid-TRIGGERED between clock edges -> outputs zero immediately without a clock edge.
- With TRACE_TIMESTAMP_EN: commits at cycles 3 and 7 after arm -> rd_ts difference = 4.
